// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI flash read sequencer: optional 0xAB wake-up, READ/FAST_READ, one-entry output buffer
module spi_flash_reader #(
  parameter int unsigned FAST_READ        = 0,
  parameter int unsigned WAKEUP_EN        = 1,
  parameter int unsigned WAKE_WAIT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [23:0] addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        spi_en_o,
  output logic [7:0]  spi_wr_data_o,
  output logic        spi_wr_valid_o,
  input  logic        spi_wr_ready_i,
  input  logic [7:0]  spi_rd_data_i,
  input  logic        spi_rd_valid_i,
  output logic        spi_rd_ready_o
);

  localparam int          NCMD     = (FAST_READ != 0) ? 5 : 4;
  localparam logic [7:0]  CMD_BYTE = (FAST_READ != 0) ? 8'h0B : 8'h03;
  localparam int          WW       = (WAKE_WAIT_CYCLES > 1) ? $clog2(WAKE_WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE_CMD, S_WAKE_END, S_WAKE_WAIT, S_CMD, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   addr_q;
  logic [15:0]   rem, rem_nxt;
  logic [2:0]    byte_idx;
  logic [2:0]    disc_cnt;
  logic [WW-1:0] wait_cnt;
  logic          wake_done;
  logic [7:0]    data_q;
  logic          data_vld;
  logic          discarding, data_pulse, wr_hs, wait_last;

  // Every completed SPI byte echoes a pulse; the first NCMD belong to the command phase.
  assign discarding = (disc_cnt != 3'(NCMD));
  assign data_pulse = (state == S_READ) && spi_rd_valid_i && !discarding;
  assign rem_nxt    = data_pulse ? rem - 16'd1 : rem;
  assign wr_hs      = spi_wr_valid_o && spi_wr_ready_i;
  assign wait_last  = (wait_cnt == WW'(WAKE_WAIT_CYCLES - 1));
  assign data_o       = data_q;
  assign data_valid_o = data_vld;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      rem       <= '0;
      byte_idx  <= '0;
      disc_cnt  <= '0;
      wait_cnt  <= '0;
      wake_done <= 1'b0;
      data_q    <= '0;
      data_vld  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start_i) begin
        addr_q   <= addr_i;
        rem      <= len_i;
        byte_idx <= '0;
        disc_cnt <= '0;
      end
      if (state == S_CMD && wr_hs)
        byte_idx <= byte_idx + 3'd1;
      if ((state == S_CMD || state == S_READ) && spi_rd_valid_i && discarding)
        disc_cnt <= disc_cnt + 3'd1;
      if (data_pulse)
        rem <= rem_nxt;
      if (state == S_WAKE_END && spi_rd_valid_i) begin
        wake_done <= 1'b1;
        wait_cnt  <= '0;
      end
      if (state == S_WAKE_WAIT)
        wait_cnt <= wait_cnt + WW'(1);
      if (data_pulse) begin
        data_q   <= spi_rd_data_i;
        data_vld <= 1'b1;
      end else if (data_vld && data_ready_i) begin
        data_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    busy_o         = (state != S_IDLE);
    done_o         = 1'b0;
    spi_en_o       = 1'b0;
    spi_wr_valid_o = 1'b0;
    spi_wr_data_o  = 8'h00;
    spi_rd_ready_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == 16'd0)                      state_nxt = S_DONE;
          else if (WAKEUP_EN != 0 && !wake_done)   state_nxt = S_WAKE_CMD;
          else                                     state_nxt = S_CMD;
        end
      end
      S_WAKE_CMD: begin
        spi_en_o       = 1'b1;
        spi_wr_valid_o = 1'b1;
        spi_wr_data_o  = 8'hAB;
        if (wr_hs) state_nxt = S_WAKE_END;
      end
      S_WAKE_END: begin
        if (spi_rd_valid_i) state_nxt = S_WAKE_WAIT;
      end
      S_WAKE_WAIT: begin
        if (wait_last) state_nxt = S_CMD;
      end
      S_CMD: begin
        spi_en_o       = 1'b1;
        spi_wr_valid_o = 1'b1;
        case (byte_idx)
          3'd0:    spi_wr_data_o = CMD_BYTE;
          3'd1:    spi_wr_data_o = addr_q[23:16];
          3'd2:    spi_wr_data_o = addr_q[15:8];
          3'd3:    spi_wr_data_o = addr_q[7:0];
          default: spi_wr_data_o = 8'h00;
        endcase
        if (wr_hs && byte_idx == 3'(NCMD - 1)) state_nxt = S_READ;
      end
      S_READ: begin
        // Dropping enable on the final byte's pulse keeps the master from clocking one more.
        spi_en_o       = (rem_nxt != 16'd0);
        spi_rd_ready_o = !data_vld && (rem_nxt != 16'd0);
        if (data_pulse && rem_nxt == 16'd0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!data_vld) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - randomized bench for spi_flash_reader with SPI master / flash / consumer model
module tb_spi_flash_reader;
  localparam int WAIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start [2];
  logic [23:0] addr [2];
  logic [15:0] len [2];
  logic        busy [2], done [2], dvalid [2], spi_en [2], wr_valid [2], rd_ready [2];
  logic [7:0]  data [2], wr_data [2];
  logic        dready [2]   = '{1'b0, 1'b0};
  logic        wr_ready [2] = '{1'b0, 1'b0};
  logic        rd_valid [2] = '{1'b0, 1'b0};
  logic [7:0]  rd_data [2]  = '{8'h00, 8'h00};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_flash_reader #(.FAST_READ(g), .WAKEUP_EN(1), .WAKE_WAIT_CYCLES(WAIT)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start[g]), .addr_i(addr[g]), .len_i(len[g]),
      .busy_o(busy[g]), .done_o(done[g]), .data_o(data[g]), .data_valid_o(dvalid[g]),
      .data_ready_i(dready[g]), .spi_en_o(spi_en[g]), .spi_wr_data_o(wr_data[g]),
      .spi_wr_valid_o(wr_valid[g]), .spi_wr_ready_i(wr_ready[g]), .spi_rd_data_i(rd_data[g]),
      .spi_rd_valid_i(rd_valid[g]), .spi_rd_ready_o(rd_ready[g])
    );
  end

  int tests = 0, fails = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    logic [7:0] m;
    m = 8'(a[7:0] * 8'd7);
    return m ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Model state per DUT instance: SPI master/flash, expectations, consumer.
  int          ticks [2];
  bit          act [2], pend_data [2], wake_m [2], exp_busy [2], last_wake [2], stall [2], got_first [2];
  logic [7:0]  pend_miso [2];
  logic [7:0]  cur_mosi [2][$];
  logic [7:0]  exp_mosi [2][$];
  int          exp_blen [2][$];
  logic [7:0]  exp_data [2][$];
  int          end_cyc [2], done_cnt [2], bursts [2], consumed [2], starts [2];
  logic [7:0]  first_byte [2], last_byte [2];
  bit          rv_n [2], wr_n [2], dr_n [2];
  logic [7:0]  rd_n [2];
  bit          p_wr_pend [2], p_d_pend [2];
  logic [7:0]  p_wr_data [2], p_data [2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      rd_valid[i] = rv_n[i];
      rd_data[i]  = rd_n[i];
      wr_ready[i] = wr_n[i];
      dready[i]   = dr_n[i];
    end
  end

  always @(negedge clk) begin
    int k, nc, L, nmis;
    bit hs, rdst, idle, pd;
    logic [7:0] miso;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        ticks[i] = 0; act[i] = 0; pend_data[i] = 0; wake_m[i] = 0; exp_busy[i] = 0;
        last_wake[i] = 0; p_wr_pend[i] = 0; p_d_pend[i] = 0;
        rv_n[i] = 0; wr_n[i] = 0; dr_n[i] = 0;
        cur_mosi[i].delete(); exp_mosi[i].delete(); exp_blen[i].delete(); exp_data[i].delete();
      end else begin
        check("busy", 32'(busy[i]), 32'(exp_busy[i]));
        if (spi_en[i]) check("en_while_busy", 32'(busy[i]), 32'd1);
        if (p_wr_pend[i]) check("wr_hold", {23'd0, wr_valid[i], wr_data[i]}, {23'd0, 1'b1, p_wr_data[i]});
        if (p_d_pend[i]) check("data_hold", {23'd0, dvalid[i], data[i]}, {23'd0, 1'b1, p_data[i]});
        if (dvalid[i] && dready[i]) begin
          if (exp_data[i].size() == 0) check("extra_byte", 32'd1, 32'd0);
          else check("data", 32'(data[i]), 32'(exp_data[i].pop_front()));
          consumed[i]++;
          if (!got_first[i]) begin first_byte[i] = data[i]; got_first[i] = 1; end
          last_byte[i] = data[i];
        end
        if (rd_valid[i] && pend_data[i]) check("no_overrun", 32'(dvalid[i]), 32'd0);
        if (ticks[i] > 0) ticks[i]--;
        if (!act[i] && spi_en[i]) begin
          act[i] = 1;
          cur_mosi[i].delete();
          if (last_wake[i]) check("wake_gap", 32'((cyc - end_cyc[i] - 1) >= WAIT), 32'd1);
          last_wake[i] = 0;
        end
        idle = (ticks[i] == 0) && !rd_valid[i];
        hs   = wr_valid[i] && wr_ready[i];
        rdst = !hs && idle && act[i] && spi_en[i] && rd_ready[i];
        if (hs || rdst) begin
          k = cur_mosi[i].size();
          miso = 8'hFF; pd = 0;
          if (k > 0) begin
            nc = (cur_mosi[i][0] == 8'h03) ? 4 : (cur_mosi[i][0] == 8'h0B) ? 5 : 0;
            if (nc != 0 && k >= nc) begin
              miso = mem({cur_mosi[i][1], cur_mosi[i][2], cur_mosi[i][3]} + 24'(k - nc));
              pd = 1;
            end
          end
          cur_mosi[i].push_back(hs ? wr_data[i] : 8'h00);
          pend_miso[i] = miso; pend_data[i] = pd;
          ticks[i] = $urandom_range(1, 4);
          starts[i]++;
        end
        if (act[i] && !spi_en[i] && ticks[i] == 0) begin
          act[i] = 0; bursts[i]++; end_cyc[i] = cyc;
          last_wake[i] = (cur_mosi[i].size() > 0) && (cur_mosi[i][0] == 8'hAB);
          if (exp_blen[i].size() == 0) check("burst_expected", 32'd0, 32'd1);
          else begin
            L = exp_blen[i].pop_front(); nmis = 0;
            check("burst_len", 32'(cur_mosi[i].size()), 32'(L));
            for (int j = 0; j < L; j++) begin
              miso = exp_mosi[i].pop_front();
              if (j < cur_mosi[i].size() && cur_mosi[i][j] !== miso) nmis++;
            end
            check("burst_bytes_mismatched", 32'(nmis), 32'd0);
          end
        end
        if (done[i]) begin
          done_cnt[i]++;
          check("done_data_left", 32'(exp_data[i].size()), 32'd0);
          check("done_bursts_left", 32'(exp_blen[i].size()), 32'd0);
          exp_busy[i] = 0;
        end
        if (start[i] && !busy[i]) begin
          exp_busy[i] = 1;
          if (len[i] != 16'd0) begin
            if (!wake_m[i]) begin
              exp_mosi[i].push_back(8'hAB); exp_blen[i].push_back(1); wake_m[i] = 1;
            end
            exp_mosi[i].push_back(i == 1 ? 8'h0B : 8'h03);
            exp_mosi[i].push_back(addr[i][23:16]);
            exp_mosi[i].push_back(addr[i][15:8]);
            exp_mosi[i].push_back(addr[i][7:0]);
            if (i == 1) exp_mosi[i].push_back(8'h00);
            for (int j = 0; j < int'(len[i]); j++) begin
              exp_mosi[i].push_back(8'h00);
              exp_data[i].push_back(mem(addr[i] + 24'(j)));
            end
            exp_blen[i].push_back(4 + i + int'(len[i]));
          end
        end
        rv_n[i] = (ticks[i] == 1);
        rd_n[i] = pend_miso[i];
        wr_n[i] = (ticks[i] == 0) && !rv_n[i];
        dr_n[i] = !stall[i] && ($urandom_range(0, 3) != 0);
        p_wr_pend[i] = wr_valid[i] && !wr_ready[i]; p_wr_data[i] = wr_data[i];
        p_d_pend[i]  = dvalid[i] && !dready[i];     p_data[i]    = data[i];
      end
    end
  end

  task automatic req(input int i, input logic [23:0] a, input logic [15:0] n, output int lat);
    int b;
    b = 0;
    while (busy[i] && b < 5000) begin @(negedge clk); b++; end
    @(posedge clk); #1;
    start[i] = 1; addr[i] = a; len[i] = n;
    @(posedge clk); #1;
    start[i] = 0; addr[i] = 24'($urandom); len[i] = 16'($urandom);
    b = 0;
    while (!done[i] && b < 5000) begin @(negedge clk); b++; end
    lat = b;
    check("req_done_seen", 32'(done[i]), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 2; i++)
      check(name, {10'd0, busy[i], done[i], dvalid[i], spi_en[i], wr_valid[i], rd_ready[i], data[i], wr_data[i]}, 32'd0);
  endtask

  initial begin
    int lat, b0, d0, c0, s0, bw;
    logic [23:0] a;
    rstn = 0;
    for (int i = 0; i < 2; i++) begin start[i] = 0; addr[i] = '0; len[i] = '0; stall[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1 rstn = 1;

    b0 = bursts[0]; d0 = done_cnt[0]; c0 = consumed[0]; got_first[0] = 0;
    req(0, 24'h000100, 16'd4, lat);
    check("t1_bursts", 32'(bursts[0] - b0), 32'd2);
    check("t1_done_pulses", 32'(done_cnt[0] - d0), 32'd1);
    check("t1_bytes", 32'(consumed[0] - c0), 32'd4);
    check("t1_first_byte", 32'(first_byte[0]), 32'h5B);

    b0 = bursts[0]; c0 = consumed[0]; got_first[0] = 0;
    req(0, 24'h00FFFE, 16'd3, lat);
    check("t2_single_burst", 32'(bursts[0] - b0), 32'd1);
    check("t2_bytes", 32'(consumed[0] - c0), 32'd3);
    check("t2_first_byte", 32'(first_byte[0]), 32'h57);
    check("t2_last_byte", 32'(last_byte[0]), 32'h5B);

    b0 = bursts[1]; c0 = consumed[1]; got_first[1] = 0;
    req(1, 24'h123456, 16'd2, lat);
    check("t3_bursts", 32'(bursts[1] - b0), 32'd2);
    check("t3_bytes", 32'(consumed[1] - c0), 32'd2);
    check("t3_first_byte", 32'(first_byte[1]), 32'h26);
    check("t3_last_byte", 32'(last_byte[1]), 32'h1D);

    b0 = bursts[0]; s0 = starts[0]; d0 = done_cnt[0];
    req(0, 24'($urandom), 16'd0, lat);
    check("t4_done_latency_ok", 32'(lat <= 1), 32'd1);
    check("t4_no_bursts", 32'(bursts[0] - b0), 32'd0);
    check("t4_no_spi_bytes", 32'(starts[0] - s0), 32'd0);
    check("t4_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    b0 = bursts[0]; c0 = consumed[0];
    fork
      req(0, 24'($urandom), 16'd8, lat);
      begin
        int s5;
        bw = 0;
        while (consumed[0] - c0 < 3 && bw < 3000) begin @(negedge clk); bw++; end
        stall[0] = 1;
        repeat (10) @(negedge clk);
        s5 = starts[0];
        repeat (40) @(negedge clk);
        check("t5_sck_idle_in_stall", 32'(starts[0] - s5), 32'd0);
        check("t5_csn_low_in_stall", 32'(act[0]), 32'd1);
        check("t5_buffer_held", 32'(dvalid[0]), 32'd1);
        stall[0] = 0;
      end
    join
    check("t5_single_burst", 32'(bursts[0] - b0), 32'd1);
    check("t5_bytes", 32'(consumed[0] - c0), 32'd8);

    c0 = consumed[0];
    @(posedge clk); #1;
    start[0] = 1; addr[0] = 24'h00A000; len[0] = 16'd8;
    @(posedge clk); #1;
    start[0] = 0;
    bw = 0;
    while (consumed[0] - c0 < 2 && bw < 3000) begin @(negedge clk); bw++; end
    check("t6_reached_byte3", 32'(consumed[0] - c0 >= 2), 32'd1);
    @(posedge clk); #1 rstn = 0;
    @(negedge clk);
    check_reset_outputs("t6_reset_outputs");
    @(posedge clk); #1 rstn = 1;
    b0 = bursts[0]; c0 = consumed[0]; d0 = done_cnt[0];
    req(0, 24'h00A000, 16'd5, lat);
    check("t6_rewake_bursts", 32'(bursts[0] - b0), 32'd2);
    check("t6_bytes", 32'(consumed[0] - c0), 32'd5);
    check("t6_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    repeat (8) begin
      int i;
      i = $urandom_range(0, 1);
      a = 24'($urandom);
      req(i, a, 16'($urandom_range(1, 6)), lat);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
